wptr_full_ctrl: RTL and testbench

WPTR_FULL_CTRL -- requirements
Module: wptr_full_ctrl

---
 rtl/wptr_full_ctrl_pkg.sv | 14 +
 rtl/wptr_full_ctrl_gray2bin.sv | 14 +
 rtl/wptr_full_ctrl.sv | 71 +++++++
 tb/tb_wptr_full_ctrl.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/wptr_full_ctrl_pkg.sv
// Shared FIFO pointer constants: default geometry and the pointer width
// used by both the write-side and read-side pointer blocks.
package wptr_full_ctrl_pkg;

    localparam int DEF_ADDR_WIDTH = 3;
    localparam int DEF_AF_THRESH  = 6;
    localparam int DEF_PTR_W      = DEF_ADDR_WIDTH + 1;

    // Pointers carry one extra wrap bit beyond the address.
    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/wptr_full_ctrl_gray2bin.sv
// Width-parameterized Gray-to-binary converter, purely combinational.
module gray2bin #(
    parameter int W = 4
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    // Each binary bit is the XOR of all Gray bits at or above it.
    for (genvar i = 0; i < W; i++) begin : g_bit
        assign bin[i] = ^gray[W-1:i];
    end

endmodule

// File: rtl/wptr_full_ctrl.sv
// Write-side FIFO pointer: binary/Gray write pointer, full/almost-full,
// occupancy and sticky overflow, all in the write clock domain.
module wptr_full_ctrl
    import wptr_full_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int AF_THRESH  = DEF_AF_THRESH
) (
    input  logic                  wclk,
    input  logic                  rst_n,
    input  logic                  winc,
    input  logic [ADDR_WIDTH:0]   rptr_sync,
    input  logic                  clr_ovf,
    output logic                  wen,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [ADDR_WIDTH:0]   wptr,
    output logic                  full,
    output logic                  almost_full,
    output logic                  overflow,
    output logic [ADDR_WIDTH:0]   wlevel
);

    localparam int PW = ptr_width(ADDR_WIDTH);

    logic [PW-1:0] wbin;
    logic [PW-1:0] wbin_next;
    logic [PW-1:0] wgray_next;
    logic [PW-1:0] rbin;
    logic [PW-1:0] rptr_full_cmp;
    logic [PW-1:0] wlevel_next;
    logic          full_next;
    logic          af_next;

    gray2bin #(.W(PW)) u_rptr_g2b (
        .gray (rptr_sync),
        .bin  (rbin)
    );

    assign wen   = winc & ~full;
    assign waddr = wbin[ADDR_WIDTH-1:0];

    assign wbin_next  = wbin + PW'(wen);
    assign wgray_next = (wbin_next >> 1) ^ wbin_next;

    // Full when the write pointer is one lap ahead: top two Gray bits inverted.
    assign rptr_full_cmp = {~rptr_sync[ADDR_WIDTH:ADDR_WIDTH-1], rptr_sync[ADDR_WIDTH-2:0]};
    assign full_next     = (wgray_next == rptr_full_cmp);

    assign wlevel_next = wbin_next - rbin;
    assign af_next     = (int'(wlevel_next) >= AF_THRESH);

    always_ff @(posedge wclk) begin
        if (!rst_n) begin
            wbin        <= '0;
            wptr        <= '0;
            wlevel      <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            wbin        <= wbin_next;
            wptr        <= wgray_next;
            wlevel      <= wlevel_next;
            full        <= full_next;
            almost_full <= af_next;
            // A new overflow event takes priority over a clear.
            overflow    <= (winc & full) | (overflow & ~clr_ovf);
        end
    end

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Bench for wptr_full_ctrl: directed scenarios then random traffic against
// an occupancy-count reference model.
module tb_wptr_full_ctrl;

    logic       wclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       winc = 1'b0;
    logic [3:0] rptr_sync = '0;
    logic       clr_ovf = 1'b0;
    logic       wen;
    logic [2:0] waddr;
    logic [3:0] wptr;
    logic       full;
    logic       almost_full;
    logic       overflow;
    logic [3:0] wlevel;

    int total = 0;
    int bad   = 0;

    // Reference model: counts of writes accepted and reads done.
    int wcnt = 0;
    int rcnt = 0;
    bit m_full = 0;
    bit m_af   = 0;
    bit m_ovf  = 0;
    int m_lvl  = 0;

    wptr_full_ctrl #(.ADDR_WIDTH(3), .AF_THRESH(6)) dut (
        .wclk        (wclk),
        .rst_n       (rst_n),
        .winc        (winc),
        .rptr_sync   (rptr_sync),
        .clr_ovf     (clr_ovf),
        .wen         (wen),
        .waddr       (waddr),
        .wptr        (wptr),
        .full        (full),
        .almost_full (almost_full),
        .overflow    (overflow),
        .wlevel      (wlevel)
    );

    always #5 wclk = ~wclk;

    function automatic int gray(input int b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit acc;
        bit old_full;
        if (!rst_n) begin
            wcnt = 0; m_full = 0; m_af = 0; m_ovf = 0; m_lvl = 0;
        end else begin
            old_full = m_full;
            acc      = winc && !m_full;
            wcnt     = wcnt + int'(acc);
            m_lvl    = (wcnt - rcnt) & 15;
            m_full   = (m_lvl == 8);
            m_af     = (m_lvl >= 6);
            m_ovf    = (winc && old_full) || (m_ovf && !clr_ovf);
        end
    endtask

    // One clock: check comb outputs, advance model, check registered outputs.
    task automatic step();
        rptr_sync = 4'(gray(rcnt & 15));
        #1;
        chk("wen", 32'(wen), 32'(winc && !m_full));
        chk("waddr", 32'(waddr), 32'(wcnt & 7));
        model_edge();
        @(posedge wclk);
        #1;
        chk("wptr", 32'(wptr), 32'(gray(wcnt & 15)));
        chk("wlevel", 32'(wlevel), 32'(m_lvl));
        chk("full", 32'(full), 32'(m_full));
        chk("almost_full", 32'(almost_full), 32'(m_af));
        chk("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    initial begin
        logic [3:0] exp_wptr [8];
        exp_wptr = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC};

        // Reset with winc held high
        @(posedge wclk); #1;
        rst_n = 0; winc = 1; rcnt = 0;
        step(); step();
        chk("rst_wptr", 32'(wptr), 32'h0);
        chk("rst_waddr", 32'(waddr), 32'h0);
        chk("rst_wlevel", 32'(wlevel), 32'h0);
        chk("rst_flags", 32'({full, almost_full, overflow}), 32'h0);

        // Fill eight entries
        rst_n = 1; winc = 1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("fill_wen", 32'(wen), 32'h1);
            chk("fill_waddr", 32'(waddr), 32'(i));
            step();
            chk("fill_wptr", 32'(wptr), 32'(exp_wptr[i]));
            if (i == 5) chk("fill_af6", 32'(almost_full), 32'h1);
        end
        chk("fill_full", 32'(full), 32'h1);
        chk("fill_lvl8", 32'(wlevel), 32'h8);

        // Write while full -> overflow, then clear
        #1;
        chk("ovf_wen", 32'(wen), 32'h0);
        step();
        chk("ovf_wptr", 32'(wptr), 32'hC);
        chk("ovf_set", 32'(overflow), 32'h1);
        winc = 0; clr_ovf = 1;
        step();
        chk("ovf_clr", 32'(overflow), 32'h0);
        clr_ovf = 0;

        // Drain one, then wrap write
        rcnt = 1;
        step();
        chk("drain_full", 32'(full), 32'h0);
        chk("drain_lvl", 32'(wlevel), 32'h7);
        winc = 1;
        #1;
        chk("wrap_waddr", 32'(waddr), 32'h0);
        step();
        chk("wrap_wptr", 32'(wptr), 32'hD);
        chk("wrap_full", 32'(full), 32'h1);
        chk("wrap_lvl", 32'(wlevel), 32'h8);

        // Set and clear collide: set wins
        clr_ovf = 1; winc = 1;
        step();
        chk("collide_ovf", 32'(overflow), 32'h1);
        clr_ovf = 0; winc = 0;

        // Mid-operation reset at level 5
        rst_n = 0; rcnt = 0;
        step();
        rst_n = 1; winc = 1;
        for (int i = 0; i < 5; i++) step();
        chk("mid_lvl5", 32'(wlevel), 32'h5);
        winc = 1; rst_n = 0;
        step();
        chk("mid_rst_all", 32'({wptr, wlevel, full, almost_full, overflow}), 32'h0);
        rst_n = 1;

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            winc    = ($urandom_range(0, 3) != 0);
            clr_ovf = ($urandom_range(0, 7) == 0);
            rst_n   = ($urandom_range(0, 99) != 0);
            if (!rst_n) rcnt = 0;
            else if ($urandom_range(0, 2) == 0)
                rcnt = rcnt + int'($urandom_range(0, wcnt - rcnt));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
